// File: rtl/bus_pkg.sv
// Shared types and constants for the bus cycle controller: one-hot state encoding,
// address/data widths and the default wait-state timeout.
package bus_pkg;

    localparam int unsigned ADDR_W           = 20;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    typedef enum logic [5:0] {
        TI = 6'b000001,
        T1 = 6'b000010,
        T2 = 6'b000100,
        T3 = 6'b001000,
        TW = 6'b010000,
        T4 = 6'b100000
    } bus_state_e;

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request/response handshake plus external bus pins of the bus cycle controller.
// master is the controller's view; slave is the view of the requester and bus device.
interface bus_cycle_ctrl_if;
    import bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ALE;
    logic              RD_N;
    logic              WR_N;
    logic              IOM;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DOUT;
    logic              DOE;
    logic [DATA_W-1:0] DIN;
    logic              READY;

    modport master (
        input  req_valid, req_write, req_io, req_addr, req_wdata, DIN, READY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ALE, RD_N, WR_N, IOM, Address, DOUT, DOE
    );

    modport slave (
        output req_valid, req_write, req_io, req_addr, req_wdata, DIN, READY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ALE, RD_N, WR_N, IOM, Address, DOUT, DOE
    );

endinterface

// File: rtl/bus_cycle_ctrl.sv
// T-state bus cycle controller (TI/T1/T2/T3/TW/T4) with a registered request and wait timeout.
// Define BUS_WAIT_STATE_EN to honour READY; otherwise READY is treated as always 1.
module bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT  // must be >= 1
) (
    input  logic             CLK,
    input  logic             RESET,
    bus_cycle_ctrl_if.master bus
);

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              io_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic req_ready;
    logic accept;
    logic ready_eff;
    logic timeout;
    logic strobe_active;
    logic drive_active;

`ifdef BUS_WAIT_STATE_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [WaitW-1:0] wait_q, wait_d;

    assign ready_eff = bus.READY;
    assign timeout   = (state_q == TW) && !bus.READY && (wait_q == WaitW'(MAX_WAIT));

    // Counts TW cycles spent so far; reaches 1 on the first TW.
    always_comb begin
        wait_d = '0;
        if (state_d == TW) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign ready_eff = 1'b1;
    assign timeout   = 1'b0;
`endif

    assign req_ready = !RESET && ((state_q == TI) || (state_q == T4));
    assign accept    = bus.req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TI:      if (accept) state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = ready_eff ? T4 : TW;
            TW:      if (ready_eff || timeout) state_d = T4;
            T4:      state_d = accept ? T1 : TI;
            default: state_d = TI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= TI;
            addr_q  <= '0;
            io_q    <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= timeout;
            if (accept) begin
                addr_q  <= bus.req_addr;
                io_q    <= bus.req_io;
                write_q <= bus.req_write;
                wdata_q <= bus.req_wdata;
            end
            // A timed-out read keeps the previous read data.
            if (((state_q == T3) || (state_q == TW)) && (state_d == T4) && !write_q && !timeout) begin
                rdata_q <= bus.DIN;
            end
        end
    end

    assign strobe_active = (state_q == T2) || (state_q == T3) || (state_q == TW);
    assign drive_active  = strobe_active || (state_q == T4);

    assign bus.req_ready = req_ready;
    assign bus.ALE       = (state_q == T1);
    assign bus.RD_N      = !(strobe_active && !write_q);
    assign bus.WR_N      = !(strobe_active && write_q);
    assign bus.DOE       = drive_active && write_q;
    assign bus.DOUT      = (drive_active && write_q) ? wdata_q : '0;
    assign bus.IOM       = io_q;
    assign bus.Address   = addr_q;
    assign bus.rsp_valid = (state_q == T4);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_q;

endmodule
